// File: rtl/ledport_sched_fta64.sv
// Round-robin scheduler that turns LED codes posted by several diagnostic sources into
// single FTA64 ERC writes to the LED port, with ack/timeout handling and a visible-hold interval.
package ledport_fta64_pkg;
  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'd0,
    CTI_FIXED   = 3'd1,
    CTI_INCR    = 3'd2,
    ERC         = 3'd7
  } fta_cycle_type_t;

  typedef enum logic [1:0] {
    OKAY    = 2'd0,
    DECERR  = 2'd1,
    PROTERR = 2'd2,
    ERR     = 2'd3
  } fta_tranerr_t;

  typedef struct packed {
    logic [7:0]      tid;
    logic            cyc;
    logic            we;
    fta_cycle_type_t cti;
    logic [7:0]      sel;
    logic [31:0]     adr;
    logic [63:0]     dat;
  } fta_cmd_request64_t;

  typedef struct packed {
    logic [7:0]   tid;
    logic         ack;
    fta_tranerr_t err;
  } fta_cmd_response64_t;
endpackage

module ledport_sched_fta64
  import ledport_fta64_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter logic [31:0] LED_ADR = 32'hFEDC0000,
  parameter int unsigned HOLD    = 1000,
  parameter int unsigned TMO     = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          src_req,
  input  logic [8*NREQ-1:0]        src_code,
  output logic [NREQ-1:0]          src_ack,
  output logic [NREQ-1:0]          src_err,
  output logic                     cs,
  output fta_cmd_request64_t       req,
  input  fta_cmd_response64_t      resp,
  output logic                     busy,
  output logic [2:0]               grant_id
);

  localparam int unsigned CMAX = (HOLD > TMO) ? HOLD : TMO;
  localparam int unsigned CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
  localparam logic [CW-1:0] TMO_C     = CW'(TMO);
  localparam logic [CW-1:0] HOLD_LAST = (HOLD == 0) ? '0 : CW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      id_q, id_d;
  logic [7:0]      code_q, code_d;
  logic [7:0]      tid_q, tid_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] rot;
  logic            pick_vld;
  logic [2:0]      pick_id;
  logic [7:0]      pick_code;
  logic [NREQ-1:0] id_oh;
  logic            ack_vld;
  logic            ack_ok;

  // Rotate requests so bit 0 is the highest-priority source, then take the first set bit.
  always_comb begin
    rot       = NREQ'({src_req, src_req} >> ptr_q);
    pick_vld  = 1'b0;
    pick_id   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!pick_vld && rot[k]) begin
        pick_vld = 1'b1;
        pick_id  = 3'((32'(ptr_q) + k) % NREQ);
      end
    end
    pick_code = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (pick_id == 3'(j)) pick_code = src_code[8*j +: 8];
    end
  end

  // tid_q has already advanced past the issued write while in WAIT.
  assign ack_vld = resp.ack && (resp.tid == (tid_q - 8'd1));
  assign ack_ok  = ack_vld && (resp.err == OKAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      code_q  <= '0;
      tid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      code_q  <= code_d;
      tid_q   <= tid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    code_d  = code_q;
    tid_d   = tid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_ISSUE;
          id_d    = pick_id;
          code_d  = pick_code;
          ptr_d   = 3'((32'(pick_id) + 1) % NREQ);
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        tid_d   = tid_q + 8'd1;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (ack_vld) begin
          if (ack_ok && (HOLD != 0)) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LAST;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == TMO_C) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulses are suppressed in a reset cycle so an aborted write never reports completion.
  always_comb begin
    cs      = 1'b0;
    req     = '0;
    src_ack = '0;
    src_err = '0;
    busy    = (state_q != ST_IDLE);
    id_oh   = '0;
    for (int unsigned j = 0; j < NREQ; j++) id_oh[j] = (id_q == 3'(j));
    if (state_q == ST_ISSUE) begin
      cs      = 1'b1;
      req.tid = tid_q;
      req.cyc = 1'b1;
      req.we  = 1'b1;
      req.cti = ERC;
      req.sel = 8'h01;
      req.adr = LED_ADR;
      req.dat = {56'd0, code_q};
    end
    if ((state_q == ST_WAIT) && !rst) begin
      if (ack_ok)                          src_ack = id_oh;
      else if (ack_vld || cnt_q == TMO_C)  src_err = id_oh;
    end
  end

  assign grant_id = id_q;

endmodule

// File: tb/tb_ledport_sched_fta64.sv
// Randomized scoreboard bench for ledport_sched_fta64: a transaction-level model predicts
// every bus write, ack/err pulse and busy/grant_id value; a monitor compares each cycle.
module tb_ledport_sched_fta64;
  import ledport_fta64_pkg::*;

  localparam int NREQ = 4;
  localparam int HOLD = 4;
  localparam int TMO  = 63;
  localparam logic [31:0] LED_ADR = 32'hFEDC0000;
  localparam int NCYC = 20000;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     src_req;
  logic [8*NREQ-1:0]   src_code;
  logic [NREQ-1:0]     src_ack;
  logic [NREQ-1:0]     src_err;
  logic                cs;
  fta_cmd_request64_t  req;
  fta_cmd_response64_t resp;
  logic                busy;
  logic [2:0]          grant_id;

  ledport_sched_fta64 #(
    .NREQ    (NREQ),
    .LED_ADR (LED_ADR),
    .HOLD    (HOLD),
    .TMO     (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_req  (src_req),
    .src_code (src_code),
    .src_ack  (src_ack),
    .src_err  (src_err),
    .cs       (cs),
    .req      (req),
    .resp     (resp),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] tid; logic [7:0] code; } wr_t;
  typedef struct { int cyc; logic [NREQ-1:0] ack; logic [NREQ-1:0] err; } pl_t;
  typedef struct { int cyc; logic busy; logic [2:0] gid; } st_t;
  typedef struct { logic [7:0] tid; fta_tranerr_t err; } rsp_t;

  wr_t  wq[$];
  pl_t  pq[$];
  st_t  sq[$];
  rsp_t plan[int];

  int vectors = 0;
  int miscompares = 0;

  // Driver plus transaction-level reference model.
  initial begin
    int n, g, iss, pc, d, kind, next_decide, rr, last_g;
    int sst[NREQ];
    int sdone[NREQ];
    logic [7:0] tid_m;
    logic is_err;
    logic [NREQ-1:0] oh;
    rst = 1'b1; src_req = '0; src_code = '0; resp = '0;
    next_decide = 1; rr = 0; last_g = 0; tid_m = 8'd0;
    for (int i = 0; i < NREQ; i++) begin sst[i] = 0; sdone[i] = 0; end
    for (int it = 0; it < NCYC; it++) begin
      @(posedge clk); #1;
      n = cyc;
      for (int i = 0; i < NREQ; i++) begin
        src_code[8*i +: 8] = 8'($urandom);
        if (sst[i] == 2 && sdone[i] < n) begin
          sst[i] = 0; src_req[i] = 1'b0;
        end else if (sst[i] == 2 && $urandom_range(0, 15) == 0) begin
          src_req[i] = 1'b0;
        end else if (sst[i] == 0 && $urandom_range(0, ((n / 2000) % 2 == 1) ? 1 : 12) == 0) begin
          sst[i] = 1; src_req[i] = 1'b1;
        end
      end
      if (plan.exists(n)) begin
        resp.ack = 1'b1; resp.tid = plan[n].tid; resp.err = plan[n].err;
      end else begin
        resp = '0;
      end
      rst = (n < 3) || ($urandom_range(0, 299) == 0);
      sq.push_back('{n, (next_decide != n), 3'(last_g)});
      if (rst) begin
        while (wq.size() > 0 && wq[$].cyc > n) void'(wq.pop_back());
        while (pq.size() > 0 && pq[$].cyc >= n) void'(pq.pop_back());
        plan.delete();
        next_decide = n + 1; rr = 0; last_g = 0; tid_m = 8'd0;
        for (int i = 0; i < NREQ; i++) if (sst[i] == 2) sdone[i] = n;
      end else if (next_decide == n) begin
        if (src_req == '0) begin
          next_decide = n + 1;
        end else begin
          g = -1;
          for (int k = 0; k < NREQ; k++)
            if (g < 0 && src_req[(rr + k) % NREQ]) g = (rr + k) % NREQ;
          rr = (g + 1) % NREQ;
          last_g = g;
          iss = n + 1;
          wq.push_back('{iss, tid_m, src_code[8*g +: 8]});
          kind = $urandom_range(0, 9);
          case (kind)
            0, 1, 2, 3, 4, 5: begin
              d = (kind == 5) ? TMO + 1 : $urandom_range(1, 5);
              plan[iss + d] = '{tid_m, OKAY};
              pc = iss + d; is_err = 1'b0; next_decide = pc + 1 + HOLD;
            end
            6: begin
              d = $urandom_range(1, 5);
              plan[iss + d] = '{tid_m, fta_tranerr_t'($urandom_range(1, 3))};
              pc = iss + d; is_err = 1'b1; next_decide = pc + 1;
            end
            7, 8: begin
              if (kind == 8) plan[iss + TMO + 2] = '{tid_m, OKAY};
              pc = iss + TMO + 1; is_err = 1'b1; next_decide = pc + 1;
            end
            default: begin
              d = $urandom_range(1, 4);
              plan[iss + d]     = '{tid_m ^ 8'h5A, OKAY};
              plan[iss + d + 3] = '{tid_m, OKAY};
              pc = iss + d + 3; is_err = 1'b0; next_decide = pc + 1 + HOLD;
            end
          endcase
          oh = '0; oh[g] = 1'b1;
          pq.push_back('{pc, is_err ? '0 : oh, is_err ? oh : '0});
          sst[g] = 2; sdone[g] = pc;
          tid_m = tid_m + 8'd1;
        end
      end
    end
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    st_t st;
    wr_t w;
    pl_t p;
    logic exp_cs;
    fta_cmd_request64_t exp_req;
    logic [NREQ-1:0] exp_ack, exp_err;
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      st = sq.pop_front();
      vectors++;
      if (busy !== st.busy || grant_id !== st.gid) begin
        miscompares++;
        $display("FAIL state cyc=%0d busy=%b grant_id=%0d expected busy=%b grant_id=%0d",
                 cyc, busy, grant_id, st.busy, st.gid);
      end
      exp_cs = 1'b0; exp_req = '0;
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        w = wq.pop_front();
        exp_cs = 1'b1;
        exp_req.tid = w.tid; exp_req.cyc = 1'b1; exp_req.we = 1'b1; exp_req.cti = ERC;
        exp_req.sel = 8'h01; exp_req.adr = LED_ADR; exp_req.dat = {56'd0, w.code};
      end
      vectors++;
      if (cs !== exp_cs || req !== exp_req) begin
        miscompares++;
        $display("FAIL bus cyc=%0d cs=%b req=%h expected cs=%b req=%h", cyc, cs, req, exp_cs, exp_req);
      end
      exp_ack = '0; exp_err = '0;
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        p = pq.pop_front();
        exp_ack = p.ack; exp_err = p.err;
      end
      vectors++;
      if (src_ack !== exp_ack || src_err !== exp_err) begin
        miscompares++;
        $display("FAIL pulse cyc=%0d src_ack=%b src_err=%b expected src_ack=%b src_err=%b",
                 cyc, src_ack, src_err, exp_ack, exp_err);
      end
    end
  end

endmodule
